shifter_pipe: RTL
=================

Name: shifter_pipe

Overview:
Parametrised, pipelined successor to the single-issue 16-bit shifter in the compute unit. Supports configurable datapath width and pipeline latency, and adds a logical shift mode. Adds saturating shift amounts, a valid output with stall support, and a sticky overflow flag visible to the program sequencer. Operands come from the crossbar (xb_*), control comes from the program sequencer (ps_*), and the result returns to the crossbar.

Parameters:
- DATASIZE, 16, operand/result width; legal values 8, 16, 32, 64 (power of two required for rotate modulo).
- LAT, 2, cycles from accepted command to shf_xb_vld; legal 1..3.
- CW, $clog2(DATASIZE)+1, count-result width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ps_shf_en  in  1  command valid; a command is accepted on a rising edge where ps_shf_en=1 and ps_shf_stall=0.
- ps_shf_cls  in  3  mode select.
- ps_shf_stall  in  1  freeze the whole pipeline.
- ps_shf_ssclr  in  1  clear the sticky overflow flag.
- xb_dtx  in  DATASIZE  Rx operand.
- xb_dty  in  DATASIZE  Ry operand: signed shift/rotate amount.
- shf_xb_dt  out  DATASIZE  result.
- shf_xb_vld  out  1  result valid.
- shf_ps_sv  out  1  overflow flag, qualified by vld.
- shf_ps_sz  out  1  zero flag, qualified by vld.
- shf_ps_ss  out  1  sticky overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: shf_xb_dt=0, shf_xb_vld=0, shf_ps_sv=0, shf_ps_sz=0, shf_ps_ss=0. All pipeline valid bits are cleared.
- Reset mid-operation: all in-flight commands are discarded. Nothing emerges after reset.
- Pipeline: stage 0 registers cls/Rx/Ry on accept. Compute is combinational after stage 0. Remaining LAT-1 register stages carry result, flags and valid.
- Throughput: one command per cycle. Issue order equals result order.
- Stall: while ps_shf_stall=1, every register (including outputs) holds its value, and ps_shf_en is ignored (the command is dropped; the issuer must not issue). shf_xb_vld keeps its held value.
- Amount n = signed(Ry). Magnitude m = |n|, computed at DATASIZE+1 bits so that -2^(DATASIZE-1) is handled.
- Modes (ps_shf_cls):
  - 000 ASHIFT: n>=0 gives Rx<<m; n<0 gives arithmetic Rx>>>m.
    - If m>=DATASIZE: left result=0; right result=all copies of Rx MSB.
    - sv (left only) = 1 if any discarded bit or the new MSB differs from the original sign, i.e. result>>>m != Rx, or (m>=DATASIZE and Rx!=0). Right shift: sv=0.
  - 001 ROT: r = m mod DATASIZE. n>=0 rotates left by r; n<0 rotates right by r. sv=0.
  - 010 LZC: result = count of leading zeros of Rx, zero-extended from CW bits. Rx=0 gives DATASIZE. sv = (count==DATASIZE).
  - 011 LOC: result = count of leading ones. Rx=all ones gives DATASIZE. sv = (count==DATASIZE).
  - 100 LSHIFT: like ASHIFT but right shift zero-fills; m>=DATASIZE gives 0.
    - sv (left only) = 1 if any 1 bit is shifted out. Right shift: sv=0.
  - 101..111 reserved: result=0, sv=0, sz=0, vld still asserted.
- sz = (result==0) for all non-reserved modes.
- Sticky flag shf_ps_ss:
  - Set on any cycle where shf_xb_vld=1, shf_ps_sv=1 and ps_shf_stall=0. A held result is counted once.
  - Cleared by ps_shf_ssclr. Set has priority over clear in the same cycle.
  - Holds during stall, except that clear still acts.
- Outputs change only on clock edges; no combinational path from inputs to outputs.

Test Plan (DATASIZE=16, LAT=2):
- ASHIFT right: Rx=F000, Ry=FFFC -> dt=FF00, sv=0, sz=0, vld exactly 2 cycles after accept.
- ASHIFT left overflow: Rx=4000, Ry=0001 -> dt=8000, sv=1, ss=1 next cycle; ss stays 1 until ssclr. Repeat with ssclr asserted in the same cycle as the set -> ss stays 1.
- ASHIFT saturation: Rx=0001, Ry=8000 -> dt=0000, sz=1, sv=0; Rx=8001, Ry=0014 -> dt=0000, sv=1.
- ROT: Rx=C000, Ry=0002 -> 0003; Rx=8888, Ry=FFFE -> 2222; Rx=0001, Ry=0012 -> 0004.
- Count modes: LZC Rx=0000 -> 0010, sv=1, sz=0. LOC Rx=FFA0 -> 0009, sv=0. LSHIFT Rx=8000, Ry=FFF1 -> 0001.
- Stall/reset: issue 3 back-to-back commands, stall 2 cycles after the first vld -> outputs held, all 3 results in order, ss set once. Then assert reset with the pipeline full -> next cycle vld=0, dt=0, ss=0, no late results.

Source files
------------

// File: rtl/shifter_pipe_if.sv
// Command, operand and result bundle between sequencer/crossbar and shifter_pipe.
// master drives commands and operands; slave (the shifter) drives results and flags.
interface shifter_pipe_if #(
    parameter int DATASIZE = 16
);
    logic                ps_shf_en;
    logic [2:0]          ps_shf_cls;
    logic                ps_shf_stall;
    logic                ps_shf_ssclr;
    logic [DATASIZE-1:0] xb_dtx;
    logic [DATASIZE-1:0] xb_dty;
    logic [DATASIZE-1:0] shf_xb_dt;
    logic                shf_xb_vld;
    logic                shf_ps_sv;
    logic                shf_ps_sz;
    logic                shf_ps_ss;

    modport master (
        output ps_shf_en, ps_shf_cls, ps_shf_stall, ps_shf_ssclr, xb_dtx, xb_dty,
        input  shf_xb_dt, shf_xb_vld, shf_ps_sv, shf_ps_sz, shf_ps_ss
    );

    modport slave (
        input  ps_shf_en, ps_shf_cls, ps_shf_stall, ps_shf_ssclr, xb_dtx, xb_dty,
        output shf_xb_dt, shf_xb_vld, shf_ps_sv, shf_ps_sz, shf_ps_ss
    );
endinterface

// File: rtl/shifter_pipe.sv
// Pipelined shifter: arithmetic/logical shift, rotate and leading zero/one count,
// with saturating amounts, stall freeze and a sticky overflow flag.
module shifter_pipe #(
    parameter int DATASIZE = 16,
    parameter int LAT      = 2,
    parameter int CW       = $clog2(DATASIZE) + 1
) (
    input logic           clk,
    input logic           reset,
    shifter_pipe_if.slave bus
);
    localparam int LW = $clog2(DATASIZE);

    localparam logic [2:0] CLS_ASHIFT = 3'b000;
    localparam logic [2:0] CLS_ROT    = 3'b001;
    localparam logic [2:0] CLS_LZC    = 3'b010;
    localparam logic [2:0] CLS_LOC    = 3'b011;
    localparam logic [2:0] CLS_LSHIFT = 3'b100;

    logic                stall;
    logic                s0_vld;
    logic [2:0]          s0_cls;
    logic [DATASIZE-1:0] s0_x;
    logic [DATASIZE-1:0] s0_y;

    assign stall = bus.ps_shf_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_vld <= 1'b0;
            s0_cls <= '0;
            s0_x   <= '0;
            s0_y   <= '0;
        end else if (!stall) begin
            s0_vld <= bus.ps_shf_en;
            if (bus.ps_shf_en) begin
                s0_cls <= bus.ps_shf_cls;
                s0_x   <= bus.xb_dtx;
                s0_y   <= bus.xb_dty;
            end
        end
    end

    function automatic logic [CW-1:0] lead_zeros(input logic [DATASIZE-1:0] v);
        logic [CW-1:0] c;
        c = CW'(DATASIZE);
        for (int i = 0; i < DATASIZE; i++) begin
            if (v[i]) c = CW'(DATASIZE - 1 - i);
        end
        return c;
    endfunction

    logic                neg;
    logic                big;
    logic [DATASIZE:0]   ny;
    logic [DATASIZE:0]   mag;
    logic [LW-1:0]       sh;
    logic [DATASIZE-1:0] shl;
    logic [DATASIZE-1:0] sra;
    logic [DATASIZE-1:0] srl;
    logic [DATASIZE-1:0] ashl_back;
    logic [DATASIZE-1:0] lshl_back;
    logic [DATASIZE-1:0] rot_l;
    logic [DATASIZE-1:0] rot_r;
    logic [CW-1:0]       lzc;
    logic [CW-1:0]       loc;
    logic [DATASIZE-1:0] res;
    logic                res_sv;
    logic                res_sz;

    logic                c_vld;
    logic [DATASIZE-1:0] c_dt;
    logic                c_sv;
    logic                c_sz;

    // Magnitude is taken one bit wider so the most negative amount stays positive.
    always_comb begin
        neg       = s0_y[DATASIZE-1];
        ny        = {neg, s0_y};
        mag       = neg ? -ny : ny;
        big       = (mag >= (DATASIZE+1)'(DATASIZE));
        sh        = mag[LW-1:0];
        shl       = s0_x << sh;
        sra       = $signed(s0_x) >>> sh;
        srl       = s0_x >> sh;
        ashl_back = $signed(shl) >>> sh;
        lshl_back = shl >> sh;
        rot_l     = '0;
        rot_r     = '0;
        for (int i = 0; i < DATASIZE; i++) begin
            rot_l[i] = s0_x[LW'(i) - sh];
            rot_r[i] = s0_x[LW'(i) + sh];
        end
        lzc    = lead_zeros(s0_x);
        loc    = lead_zeros(~s0_x);
        res    = '0;
        res_sv = 1'b0;
        case (s0_cls)
            CLS_ASHIFT: begin
                if (!neg) begin
                    res    = big ? '0 : shl;
                    res_sv = big ? (s0_x != '0) : (ashl_back != s0_x);
                end else begin
                    res    = big ? {DATASIZE{s0_x[DATASIZE-1]}} : sra;
                end
            end
            CLS_ROT: res = neg ? rot_r : rot_l;
            CLS_LZC: begin
                res    = {{(DATASIZE-CW){1'b0}}, lzc};
                res_sv = (lzc == CW'(DATASIZE));
            end
            CLS_LOC: begin
                res    = {{(DATASIZE-CW){1'b0}}, loc};
                res_sv = (loc == CW'(DATASIZE));
            end
            CLS_LSHIFT: begin
                if (!neg) begin
                    res    = big ? '0 : shl;
                    res_sv = big ? (s0_x != '0) : (lshl_back != s0_x);
                end else begin
                    res    = big ? '0 : srl;
                end
            end
            default: begin
                res    = '0;
                res_sv = 1'b0;
            end
        endcase
        res_sz = (s0_cls <= CLS_LSHIFT) && (res == '0);
        c_vld  = s0_vld;
        c_dt   = res;
        c_sv   = s0_vld & res_sv;
        c_sz   = s0_vld & res_sz;
    end

    logic                out_vld;
    logic [DATASIZE-1:0] out_dt;
    logic                out_sv;
    logic                out_sz;

    generate
        if (LAT == 1) begin : g_direct
            assign out_vld = c_vld;
            assign out_dt  = c_dt;
            assign out_sv  = c_sv;
            assign out_sz  = c_sz;
        end else begin : g_pipe
            logic                p_vld [LAT-1];
            logic [DATASIZE-1:0] p_dt  [LAT-1];
            logic                p_sv  [LAT-1];
            logic                p_sz  [LAT-1];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LAT-1; i++) begin
                        p_vld[i] <= 1'b0;
                        p_dt[i]  <= '0;
                        p_sv[i]  <= 1'b0;
                        p_sz[i]  <= 1'b0;
                    end
                end else if (!stall) begin
                    p_vld[0] <= c_vld;
                    p_dt[0]  <= c_dt;
                    p_sv[0]  <= c_sv;
                    p_sz[0]  <= c_sz;
                    for (int i = 1; i < LAT-1; i++) begin
                        p_vld[i] <= p_vld[i-1];
                        p_dt[i]  <= p_dt[i-1];
                        p_sv[i]  <= p_sv[i-1];
                        p_sz[i]  <= p_sz[i-1];
                    end
                end
            end

            assign out_vld = p_vld[LAT-2];
            assign out_dt  = p_dt[LAT-2];
            assign out_sv  = p_sv[LAT-2];
            assign out_sz  = p_sz[LAT-2];
        end
    endgenerate

    // Only unstalled edges count, so a result held through a stall sets the flag once.
    logic ss;
    always_ff @(posedge clk) begin
        if (reset) begin
            ss <= 1'b0;
        end else if (out_vld && out_sv && !stall) begin
            ss <= 1'b1;
        end else if (bus.ps_shf_ssclr) begin
            ss <= 1'b0;
        end
    end

    assign bus.shf_xb_vld = out_vld;
    assign bus.shf_xb_dt  = out_dt;
    assign bus.shf_ps_sv  = out_sv;
    assign bus.shf_ps_sz  = out_sz;
    assign bus.shf_ps_ss  = ss;
endmodule
